// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the ALU system datapath.
// It fetches a 16-bit instruction into the IR as two byte cycles (T0 low, T1 high).
// It then decodes the registered IROut and drives every datapath control line.
// Only the state and the sequence counter are registered; all outputs are
// decoded combinationally from state, counter, IROut and Flags.
//
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   defined   -> an undefined opcode traps into HALT at the end of T2
//   undefined -> an undefined opcode runs as a 3-cycle NOP
module control_sequencer #(
  parameter int T_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [2:0]  RF_FunSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [4:0]  ALU_FunSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [7:0]  T,
  output logic        Halted
);

  typedef enum logic [1:0] {
    FETCH_L = 2'd0,
    FETCH_H = 2'd1,
    EXEC    = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Opcodes understood by the decoder
  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_INC = 6'h05;
  localparam logic [5:0] OP_ADD = 6'h0A;
  localparam logic [5:0] OP_ADC = 6'h0B;
  localparam logic [5:0] OP_IMM = 6'h12;
  localparam logic [5:0] OP_HLT = 6'h3F;

  // Sequence step values
  localparam logic [T_BITS-1:0] T_STEP0 = T_BITS'(0);
  localparam logic [T_BITS-1:0] T_STEP1 = T_BITS'(1);
  localparam logic [T_BITS-1:0] T_STEP2 = T_BITS'(2);
  localparam logic [T_BITS-1:0] T_STEP3 = T_BITS'(3);

  // Encodings shared by several instructions
  localparam logic [2:0] RF_FUN_INC  = 3'b001;
  localparam logic [2:0] RF_FUN_LOAD = 3'b010;
  localparam logic [4:0] ALU_PASS_A  = 5'b10000;
  localparam logic [4:0] ALU_ADD     = 5'b10100;
  localparam logic [4:0] ALU_ADC     = 5'b10101;
  localparam logic [1:0] MUX_ALU     = 2'b00;
  localparam logic [1:0] MUX_IR_LOW  = 2'b11;
  localparam logic [2:0] ARF_SEL_PC  = 3'b100;
  localparam logic [1:0] ARF_FUN_INC = 2'b01;
  localparam logic [1:0] ARF_FUN_LD  = 2'b10;

  state_t            state;
  logic [T_BITS-1:0] t_cnt;

  // Instruction fields of the registered IR
  logic [5:0] opcode;
  logic [1:0] dst;
  logic [1:0] src1;
  logic [1:0] src2;
  logic       flag_z;
  logic       op_defined;
  logic       enter_halt;
  logic       unused_inputs;

  assign opcode = IROut[15:10];
  assign dst    = IROut[9:8];
  assign src1   = IROut[7:6];
  assign src2   = IROut[5:4];
  assign flag_z = Flags[3];

  // The low IR nibble and the C/N/O flags are consumed by the datapath, not here
  assign unused_inputs = ^{IROut[3:0], Flags[2:0]};

  // Register field 00..11 selects R1..R4; R1 is the MSB of RF_RegSel
  function automatic logic [3:0] reg_enable(input logic [1:0] sel);
    return 4'b1000 >> sel;
  endfunction

  // Classify the opcode as one the decoder implements
  always_comb begin
    unique case (opcode)
      OP_BRA, OP_BNE, OP_INC, OP_ADD,
      OP_ADC, OP_IMM, OP_HLT: op_defined = 1'b1;
      default:                op_defined = 1'b0;
    endcase
  end

  // Decide whether the current T2 step finishes in HALT
`ifdef CU_ILLEGAL_TRAP_EN
  assign enter_halt = (opcode == OP_HLT) || !op_defined;
`else
  assign enter_halt = (opcode == OP_HLT);
`endif

  // State and sequence counter; an out-of-range counter recovers to T0
  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH_L;
      t_cnt <= T_STEP0;
    end else begin
      unique case (state)
        FETCH_L: begin
          state <= FETCH_H;
          t_cnt <= T_STEP1;
        end
        FETCH_H: begin
          state <= EXEC;
          t_cnt <= T_STEP2;
        end
        EXEC: begin
          if (t_cnt == T_STEP2 && opcode == OP_INC) begin
            state <= EXEC;
            t_cnt <= T_STEP3;
          end else if (t_cnt == T_STEP2 && enter_halt) begin
            state <= HALT;
            t_cnt <= T_STEP0;
          end else begin
            // Last step of the instruction or an illegal counter value
            state <= FETCH_L;
            t_cnt <= T_STEP0;
          end
        end
        HALT: begin
          // Only reset leaves HALT; keep the counter parked at zero
          state <= HALT;
          t_cnt <= T_STEP0;
        end
        default: begin
          state <= FETCH_L;
          t_cnt <= T_STEP0;
        end
      endcase
    end
  end

  // One-hot step indicator and halt flag; T reads all-zero while halted
  always_comb begin
    T      = 8'd0;
    Halted = 1'b0;
    if (state == HALT) begin
      Halted = 1'b1;
    end else begin
      T = 8'd1 << t_cnt;
    end
  end

  // Decode state, counter, IR and flags into the datapath control lines
  // NOTE: every output gets its idle default first so no path through the
  // case statements can leave a value unassigned and infer a latch.
  always_comb begin
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    RF_FunSel   = 3'b000;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    ALU_FunSel  = 5'b00000;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;
    ARF_RegSel  = 3'b000;
    ARF_FunSel  = 2'b00;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;

    unique case (state)
      FETCH_L, FETCH_H: begin
        // Read M[PC] into one IR byte and advance PC
        Mem_CS      = 1'b0;
        ARF_OutDSel = 2'b00;
        IR_Write    = 1'b1;
        IR_LH       = (state == FETCH_H);
        ARF_RegSel  = ARF_SEL_PC;
        ARF_FunSel  = ARF_FUN_INC;
      end

      EXEC: begin
        if (t_cnt == T_STEP2) begin
          unique case (opcode)
            OP_BRA: begin
              MuxBSel    = MUX_IR_LOW;
              ARF_RegSel = ARF_SEL_PC;
              ARF_FunSel = ARF_FUN_LD;
            end
            OP_BNE: begin
              if (!flag_z) begin
                MuxBSel    = MUX_IR_LOW;
                ARF_RegSel = ARF_SEL_PC;
                ARF_FunSel = ARF_FUN_LD;
              end
            end
            OP_INC: begin
              // Copy S1 into DST; the increment follows in T3
              RF_OutASel = {1'b0, src1};
              ALU_FunSel = ALU_PASS_A;
              MuxASel    = MUX_ALU;
              RF_RegSel  = reg_enable(dst);
              RF_FunSel  = RF_FUN_LOAD;
            end
            OP_ADD, OP_ADC: begin
              RF_OutASel = {1'b0, src1};
              RF_OutBSel = {1'b0, src2};
              ALU_FunSel = (opcode == OP_ADC) ? ALU_ADC : ALU_ADD;
              MuxASel    = MUX_ALU;
              RF_RegSel  = reg_enable(dst);
              RF_FunSel  = RF_FUN_LOAD;
            end
            OP_IMM: begin
              MuxASel   = MUX_IR_LOW;
              RF_RegSel = reg_enable(dst);
              RF_FunSel = RF_FUN_LOAD;
            end
            default: begin
              // HLT and undefined opcodes drive idle lines in T2
            end
          endcase
        end else if (t_cnt == T_STEP3 && opcode == OP_INC) begin
          RF_RegSel = reg_enable(dst);
          RF_FunSel = RF_FUN_INC;
        end
      end

      HALT: begin
        // Idle defaults only
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed instruction sequence with a
// queue of expected control words, compared half a cycle after each edge.
module tb_control_sequencer;

  logic        clock;
  logic        reset;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [2:0]  RF_FunSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [4:0]  ALU_FunSel;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  MuxCSel;
  logic        MuxDSel;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_FunSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [7:0]  T;
  logic        Halted;

  typedef struct packed {
    logic [3:0] rf_regsel;
    logic [3:0] rf_scrsel;
    logic [2:0] rf_funsel;
    logic [2:0] rf_outa;
    logic [2:0] rf_outb;
    logic [4:0] alu_funsel;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic [1:0] mux_c;
    logic       mux_d;
    logic [2:0] arf_regsel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_outc;
    logic [1:0] arf_outd;
    logic       ir_lh;
    logic       ir_write;
    logic       dr_e;
    logic [1:0] dr_funsel;
    logic       mem_cs;
    logic       mem_wr;
    logic [7:0] t;
    logic       halted;
  } ctrl_t;

  ctrl_t obs;
  ctrl_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {RF_RegSel, RF_ScrSel, RF_FunSel, RF_OutASel, RF_OutBSel,
                ALU_FunSel, MuxASel, MuxBSel, MuxCSel, MuxDSel, ARF_RegSel,
                ARF_FunSel, ARF_OutCSel, ARF_OutDSel, IR_LH, IR_Write, DR_E,
                DR_FunSel, Mem_CS, Mem_WR, T, Halted};

  control_sequencer #(.T_BITS(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .IROut       (IROut),
    .Flags       (Flags),
    .RF_RegSel   (RF_RegSel),
    .RF_ScrSel   (RF_ScrSel),
    .RF_FunSel   (RF_FunSel),
    .RF_OutASel  (RF_OutASel),
    .RF_OutBSel  (RF_OutBSel),
    .ALU_FunSel  (ALU_FunSel),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .MuxDSel     (MuxDSel),
    .ARF_RegSel  (ARF_RegSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_OutCSel (ARF_OutCSel),
    .ARF_OutDSel (ARF_OutDSel),
    .IR_LH       (IR_LH),
    .IR_Write    (IR_Write),
    .DR_E        (DR_E),
    .DR_FunSel   (DR_FunSel),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .T           (T),
    .Halted      (Halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Idle control word at sequence step t
  function automatic ctrl_t idle_exp(input int t);
    ctrl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    c.t      = 8'(1 << t);
    return c;
  endfunction

  // Fetch of the low (lh=0, T0) or high (lh=1, T1) instruction byte
  function automatic ctrl_t fetch_exp(input logic lh);
    ctrl_t c;
    c            = idle_exp(lh ? 1 : 0);
    c.mem_cs     = 1'b0;
    c.ir_write   = 1'b1;
    c.ir_lh      = lh;
    c.arf_regsel = 3'b100;
    c.arf_funsel = 2'b01;
    return c;
  endfunction

  function automatic ctrl_t halt_exp();
    ctrl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    c.halted = 1'b1;
    return c;
  endfunction

  // Pop the oldest expectation and compare it with the live outputs
  task automatic compare_head();
    ctrl_t exp;
    string tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and check just after it
  task automatic run_cycle(input string tag, input logic [15:0] ir,
                           input logic [3:0] flg, input logic rst,
                           input ctrl_t exp);
    @(negedge clock);
    reset = rst;
    IROut = ir;
    Flags = flg;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    compare_head();
  endtask

  ctrl_t e;

  initial begin
    reset = 1'b1;
    IROut = 16'h2810;
    Flags = 4'b0000;
    repeat (2) @(posedge clock);

    // Release reset: first cycle is FETCH_L, then FETCH_H
    run_cycle("rst_t0", 16'h2810, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("rst_t1", 16'h2810, 4'b0000, 1'b0, fetch_exp(1'b1));

    // Asynchronous reset mid-T1 forces FETCH_L immediately
    #2;
    reset = 1'b1;
    exp_q.push_back(fetch_exp(1'b0));
    tag_q.push_back("async_rst_mid_t1");
    #1;
    compare_head();

    // ADD R1 <- R1 + R2
    run_cycle("add_t0", 16'h2810, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("add_t1", 16'h2810, 4'b0000, 1'b0, fetch_exp(1'b1));
    e = idle_exp(2);
    e.rf_outa = 3'b000; e.rf_outb = 3'b001; e.alu_funsel = 5'b10100;
    e.rf_regsel = 4'b1000; e.rf_funsel = 3'b010;
    run_cycle("add_t2", 16'h2810, 4'b0000, 1'b0, e);

    // BNE 0x55 with Z=0: branch taken
    run_cycle("bne_taken_t0", 16'h0455, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("bne_taken_t1", 16'h0455, 4'b0000, 1'b0, fetch_exp(1'b1));
    e = idle_exp(2);
    e.mux_b = 2'b11; e.arf_regsel = 3'b100; e.arf_funsel = 2'b10;
    run_cycle("bne_taken_t2", 16'h0455, 4'b0000, 1'b0, e);

    // BNE 0x55 with Z=1: idle T2
    run_cycle("bne_nt_t0", 16'h0455, 4'b1000, 1'b0, fetch_exp(1'b0));
    run_cycle("bne_nt_t1", 16'h0455, 4'b1000, 1'b0, fetch_exp(1'b1));
    run_cycle("bne_nt_t2", 16'h0455, 4'b1000, 1'b0, idle_exp(2));

    // INC R3 <- R2 + 1 : load in T2, increment in T3
    run_cycle("inc_t0", 16'h1640, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("inc_t1", 16'h1640, 4'b0000, 1'b0, fetch_exp(1'b1));
    e = idle_exp(2);
    e.rf_outa = 3'b001; e.alu_funsel = 5'b10000;
    e.rf_regsel = 4'b0010; e.rf_funsel = 3'b010;
    run_cycle("inc_t2", 16'h1640, 4'b0000, 1'b0, e);
    e = idle_exp(3);
    e.rf_regsel = 4'b0010; e.rf_funsel = 3'b001;
    run_cycle("inc_t3", 16'h1640, 4'b0000, 1'b0, e);

    // ADC R1 <- R1 + R2 + C (carry flag set, must not matter to the decode)
    run_cycle("adc_t0", 16'h2C10, 4'b0100, 1'b0, fetch_exp(1'b0));
    run_cycle("adc_t1", 16'h2C10, 4'b0100, 1'b0, fetch_exp(1'b1));
    e = idle_exp(2);
    e.rf_outa = 3'b000; e.rf_outb = 3'b001; e.alu_funsel = 5'b10101;
    e.rf_regsel = 4'b1000; e.rf_funsel = 3'b010;
    run_cycle("adc_t2", 16'h2C10, 4'b0100, 1'b0, e);

    // IMM R4 <- IR[7:0]
    run_cycle("imm_t0", 16'h4BA5, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("imm_t1", 16'h4BA5, 4'b0000, 1'b0, fetch_exp(1'b1));
    e = idle_exp(2);
    e.mux_a = 2'b11; e.rf_regsel = 4'b0001; e.rf_funsel = 3'b010;
    run_cycle("imm_t2", 16'h4BA5, 4'b0000, 1'b0, e);

    // BRA 0x7F: unconditional, Z=1 must not suppress it
    run_cycle("bra_t0", 16'h007F, 4'b1000, 1'b0, fetch_exp(1'b0));
    run_cycle("bra_t1", 16'h007F, 4'b1000, 1'b0, fetch_exp(1'b1));
    e = idle_exp(2);
    e.mux_b = 2'b11; e.arf_regsel = 3'b100; e.arf_funsel = 2'b10;
    run_cycle("bra_t2", 16'h007F, 4'b1000, 1'b0, e);

    // Undefined opcode 0x0C
    run_cycle("undef_t0", 16'h3000, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("undef_t1", 16'h3000, 4'b0000, 1'b0, fetch_exp(1'b1));
    run_cycle("undef_t2", 16'h3000, 4'b0000, 1'b0, idle_exp(2));
`ifdef CU_ILLEGAL_TRAP_EN
    run_cycle("undef_trap", 16'h3000, 4'b0000, 1'b0, halt_exp());
    run_cycle("undef_trap_hold", 16'h3000, 4'b0000, 1'b0, halt_exp());
    run_cycle("undef_trap_rst", 16'hFC00, 4'b0000, 1'b1, fetch_exp(1'b0));
`endif

    // HLT: halted and idle for 10 cycles, then reset recovers
    run_cycle("hlt_t0", 16'hFC00, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("hlt_t1", 16'hFC00, 4'b0000, 1'b0, fetch_exp(1'b1));
    run_cycle("hlt_t2", 16'hFC00, 4'b0000, 1'b0, idle_exp(2));
    for (int i = 0; i < 10; i++) begin
      run_cycle($sformatf("halt_hold_%0d", i), 16'h2810, 4'b1111, 1'b0, halt_exp());
    end
    run_cycle("halt_rst", 16'h2810, 4'b0000, 1'b1, fetch_exp(1'b0));
    run_cycle("post_halt_t0", 16'h2810, 4'b0000, 1'b0, fetch_exp(1'b0));
    run_cycle("post_halt_t1", 16'h2810, 4'b0000, 1'b0, fetch_exp(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
